// File: rtl/img_frame_streamer.sv
// rtl/img_frame_streamer.sv - replays a stored image from lane-packed memory as an FVAL/DVAL pixel stream
module img_frame_streamer #(
    parameter int PIX_W       = 16,
    parameter int LANES       = 16,
    parameter int NWORDS      = 49,
    parameter int ADDR_W      = 7,
    parameter int FRONT_PORCH = 2,
    parameter int BACK_PORCH  = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        iEnable,
    input  logic                        iStart,
    input  logic                        iStall,
    output logic                        oMem_rden,
    output logic [ADDR_W-1:0]           oMem_addr,
    input  logic [LANES-1:0][PIX_W-1:0] iMem_data,
    output logic                        oFVAL,
    output logic                        oDVAL,
    output logic [PIX_W-1:0]            oDATA,
    output logic                        oBusy,
    output logic                        oDone
);

    localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int PCW   = 10;
    localparam int TOTAL = NWORDS * LANES;

    typedef enum logic [2:0] {IDLE, FETCH, FRONT, STREAM, BACK} state_t;

    state_t                    state_q, state_d;
    logic [LW-1:0]             lane_q, lane_d;
    logic [ADDR_W-1:0]         word_q, word_d;
    logic [PCW-1:0]            pix_q, pix_d;
    logic [7:0]                cnt_q, cnt_d;
    logic [LANES-1:0][PIX_W-1:0] buf_q, buf_d;
    logic [LANES-1:0][PIX_W-1:0] pref_q, pref_d;
    logic                      pend_q, pend_d;
    logic                      rden_q, rden_d;
    logic [ADDR_W-1:0]         addr_q, addr_d;
    logic                      fval_q, fval_d;
    logic                      dval_q, dval_d;
    logic [PIX_W-1:0]          data_q, data_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;

    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        word_d  = word_q;
        pix_d   = pix_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        // read data returns the cycle after the strobe; pend_q marks that cycle
        pend_d  = rden_q;
        pref_d  = pend_q ? iMem_data : pref_q;
        rden_d  = 1'b0;
        addr_d  = addr_q;
        fval_d  = fval_q;
        dval_d  = 1'b0;
        data_d  = '0;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                fval_d = 1'b0;
                if (iEnable && iStart) begin
                    state_d = FETCH;
                    rden_d  = 1'b1;
                    addr_d  = '0;
                    lane_d  = '0;
                    word_d  = '0;
                    pix_d   = '0;
                    cnt_d   = '0;
                end
            end
            FETCH: begin
                if (pend_q) begin
                    buf_d   = iMem_data;
                    fval_d  = 1'b1;
                    cnt_d   = '0;
                    // the first STREAM cycle is itself porch, so FRONT holds FRONT_PORCH-1 cycles
                    state_d = (FRONT_PORCH <= 1) ? STREAM : FRONT;
                end
            end
            FRONT: begin
                cnt_d = cnt_q + 8'd1;
                if (int'(cnt_q) >= FRONT_PORCH - 2) begin
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (!iStall) begin
                    dval_d = 1'b1;
                    data_d = buf_q[lane_q];
                    pix_d  = pix_q + 10'd1;
                    if (lane_q == '0 && word_q != ADDR_W'(NWORDS - 1)) begin
                        rden_d = 1'b1;
                        addr_d = word_q + ADDR_W'(1);
                    end
                    if (lane_q == LW'(LANES - 1)) begin
                        lane_d = '0;
                        word_d = word_q + ADDR_W'(1);
                        buf_d  = pref_q;
                    end else begin
                        lane_d = lane_q + LW'(1);
                    end
                    if (pix_q == PCW'(TOTAL - 1)) begin
                        state_d = BACK;
                        cnt_d   = '0;
                    end
                end
            end
            BACK: begin
                if (int'(cnt_q) >= BACK_PORCH) begin
                    fval_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_q != IDLE && !iEnable) begin
            state_d = IDLE;
            fval_d  = 1'b0;
            dval_d  = 1'b0;
            data_d  = '0;
            rden_d  = 1'b0;
            done_d  = 1'b0;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            lane_q  <= '0;
            word_q  <= '0;
            pix_q   <= '0;
            cnt_q   <= '0;
            buf_q   <= '0;
            pref_q  <= '0;
            pend_q  <= 1'b0;
            rden_q  <= 1'b0;
            addr_q  <= '0;
            fval_q  <= 1'b0;
            dval_q  <= 1'b0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            word_q  <= word_d;
            pix_q   <= pix_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            pref_q  <= pref_d;
            pend_q  <= pend_d;
            rden_q  <= rden_d;
            addr_q  <= addr_d;
            fval_q  <= fval_d;
            dval_q  <= dval_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign oMem_rden = rden_q;
    assign oMem_addr = addr_q;
    assign oFVAL     = fval_q;
    assign oDVAL     = dval_q;
    assign oDATA     = data_q;
    assign oBusy     = busy_q;
    assign oDone     = done_q;

endmodule

// File: tb/tb_img_frame_streamer.sv
// tb/tb_img_frame_streamer.sv - randomized directed bench for img_frame_streamer against a frame-level model
module tb_img_frame_streamer;

    localparam int PIX_W  = 16;
    localparam int LANES  = 16;
    localparam int NWORDS = 49;
    localparam int ADDR_W = 7;
    localparam int NPIX   = NWORDS * LANES;

    typedef logic [LANES-1:0][PIX_W-1:0] word_t;

    typedef struct {
        bit fval;
        bit dval;
        bit done;
        bit rden;
        bit busy;
        int data;
        int addr;
    } smp_t;

    typedef struct {
        int npix, bad_seq, front, back, fval_hi, gaps, ndone, done_bad;
        int nzero_bad, nreads, bad_addr, first_rden, first_fval, rises, min_low;
    } res_t;

    logic clk = 1'b0;
    logic rst_n, en, start, stall;

    logic              a_rden, a_fval, a_dval, a_busy, a_done;
    logic [ADDR_W-1:0] a_addr;
    logic [PIX_W-1:0]  a_data;
    word_t             a_rdata;

    logic              b_rden, b_fval, b_dval, b_busy, b_done;
    logic [ADDR_W-1:0] b_addr;
    logic [PIX_W-1:0]  b_data;
    word_t             b_rdata;

    int   vectors = 0;
    int   errors  = 0;
    smp_t tra[$];
    smp_t trb[$];

    always #5 clk = ~clk;

    img_frame_streamer u_dut (
        .clk(clk), .rst_n(rst_n), .iEnable(en), .iStart(start), .iStall(stall),
        .oMem_rden(a_rden), .oMem_addr(a_addr), .iMem_data(a_rdata),
        .oFVAL(a_fval), .oDVAL(a_dval), .oDATA(a_data), .oBusy(a_busy), .oDone(a_done)
    );

    img_frame_streamer #(.FRONT_PORCH(3), .BACK_PORCH(0)) u_dut_porch (
        .clk(clk), .rst_n(rst_n), .iEnable(en), .iStart(start), .iStall(stall),
        .oMem_rden(b_rden), .oMem_addr(b_addr), .iMem_data(b_rdata),
        .oFVAL(b_fval), .oDVAL(b_dval), .oDATA(b_data), .oBusy(b_busy), .oDone(b_done)
    );

    function automatic word_t mem_word(input logic [ADDR_W-1:0] a);
        word_t w;
        for (int l = 0; l < LANES; l++) w[l] = PIX_W'(int'(a) * LANES + l);
        return w;
    endfunction

    always @(posedge clk) begin
        if (a_rden) a_rdata <= mem_word(a_addr);
        if (b_rden) b_rdata <= mem_word(b_addr);
    end

    always @(negedge clk) begin
        tra.push_back('{fval: a_fval, dval: a_dval, done: a_done, rden: a_rden, busy: a_busy,
                        data: int'(a_data), addr: int'(a_addr)});
        trb.push_back('{fval: b_fval, dval: b_dval, done: b_done, rden: b_rden, busy: b_busy,
                        data: int'(b_data), addr: int'(b_addr)});
    end

    // every frame is pixels 0..NPIX-1 in order and reads words 0..NWORDS-1 in order
    function automatic res_t analyze(input smp_t q[$]);
        res_t r;
        bit   prev_f = 1'b0;
        bit   seen   = 1'b0;
        int   pend   = 0;
        int   low    = 0;
        r = '{default: 0};
        r.first_rden = -1;
        r.first_fval = -1;
        r.min_low    = 1000000;
        foreach (q[i]) begin
            if (q[i].rden) begin
                if (q[i].addr != r.nreads % NWORDS) r.bad_addr++;
                if (r.first_rden < 0) r.first_rden = i;
                r.nreads++;
            end
            if (!q[i].dval && q[i].data != 0) r.nzero_bad++;
            if (q[i].dval) begin
                if (q[i].data != r.npix % NPIX) r.bad_seq++;
                r.npix++;
                r.gaps += pend;
                pend = 0;
                seen = 1'b1;
            end else if (q[i].fval) begin
                if (seen) pend++;
                else r.front++;
            end
            if (q[i].fval) begin
                r.fval_hi++;
                if (!prev_f) begin
                    r.rises++;
                    if (r.first_fval < 0) r.first_fval = i;
                    if (r.rises > 1 && low < r.min_low) r.min_low = low;
                end
            end
            if (q[i].done) begin
                r.ndone++;
                if (!(prev_f && !q[i].fval)) r.done_bad++;
            end
            if (prev_f && !q[i].fval) begin
                r.back += pend;
                pend = 0;
                seen = 1'b0;
                low  = 0;
            end
            if (!q[i].fval) low++;
            prev_f = q[i].fval;
        end
        return r;
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_pix(input int v);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(a_dval && int'(a_data) == v) && n < 3000);
        if (n >= 3000) check("wait_pix_timeout", v, -1);
    endtask

    task automatic wait_done();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!a_done && n < 3000);
        if (n >= 3000) check("wait_done_timeout", 0, 1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic stall_for(input int len);
        stall = 1'b1;
        repeat (len) @(negedge clk);
        stall = 1'b0;
    endtask

    task automatic check_full(input string tag, input res_t r, input int frames, input int gaps);
        check({tag, "_npix"},     r.npix,      frames * NPIX);
        check({tag, "_seq"},      r.bad_seq,   0);
        check({tag, "_reads"},    r.nreads,    frames * NWORDS);
        check({tag, "_addr"},     r.bad_addr,  0);
        check({tag, "_ndone"},    r.ndone,     frames);
        check({tag, "_done_pos"}, r.done_bad,  0);
        check({tag, "_gaps"},     r.gaps,      gaps);
        check({tag, "_fval_len"}, r.fval_hi,   frames * (2 + NPIX + 2) + gaps);
        check({tag, "_data0"},    r.nzero_bad, 0);
    endtask

    initial begin
        res_t r;
        int   p1, p2, l1, l2, stall_sum;

        rst_n = 1'b0; en = 1'b0; start = 1'b0; stall = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", int'({a_rden, a_addr, a_fval, a_dval, a_data, a_busy, a_done}), 0);
        rst_n = 1'b1;
        en    = 1'b1;
        repeat (4) @(negedge clk);
        check("idle_no_start", int'({a_fval, a_busy, a_rden, a_done}), 0);

        // plain frame, both porch configurations
        tra.delete(); trb.delete();
        pulse_start();
        wait_done();
        repeat (4) @(negedge clk);
        r = analyze(tra);
        check_full("f1", r, 1, 0);
        check("f1_front", r.front, 2);
        check("f1_back",  r.back,  2);
        check("f1_rden_to_fval", r.first_fval - r.first_rden, 2);
        r = analyze(trb);
        check("porch_npix",  r.npix,    NPIX);
        check("porch_seq",   r.bad_seq, 0);
        check("porch_front", r.front,   3);
        check("porch_back",  r.back,    0);
        check("porch_ndone", r.ndone,   1);

        // stalls at a word boundary, mid-frame and at random spots; mid-frame start must be ignored
        p1 = 430 + $urandom_range(0, 100);
        p2 = 600 + $urandom_range(0, 150);
        l1 = $urandom_range(1, 8);
        l2 = $urandom_range(1, 8);
        stall_sum = 1 + 5 + l1 + l2;
        tra.delete(); trb.delete();
        pulse_start();
        wait_pix(15);
        stall_for(1);
        wait_pix(300);
        pulse_start();
        wait_pix(400);
        stall_for(5);
        wait_pix(p1);
        stall_for(l1);
        wait_pix(p2);
        stall_for(l2);
        wait_done();
        repeat (6) @(negedge clk);
        r = analyze(tra);
        check_full("stall", r, 1, stall_sum);
        check("stall_rises", r.rises, 1);
        check("stall_idle_after", int'({a_fval, a_busy}), 0);

        // enable dropped mid-frame
        tra.delete();
        pulse_start();
        wait_pix(200);
        en = 1'b0;
        @(negedge clk);
        check("abort_outputs", int'({a_fval, a_dval, a_busy, a_rden}), 0);
        repeat (10) @(negedge clk);
        r = analyze(tra);
        check("abort_ndone", r.ndone, 0);
        check("abort_npix",  r.npix,  201);
        en = 1'b1;
        @(negedge clk);
        tra.delete();
        pulse_start();
        wait_done();
        repeat (3) @(negedge clk);
        r = analyze(tra);
        check_full("restart", r, 1, 0);

        // start held high for three back-to-back frames
        tra.delete();
        start = 1'b1;
        for (int f = 0; f < 3; f++) wait_done();
        start = 1'b0;
        repeat (6) @(negedge clk);
        r = analyze(tra);
        check_full("b2b", r, 3, 0);
        check("b2b_rises", r.rises, 3);
        check("b2b_low_gap", int'(r.min_low >= 1), 1);

        // asynchronous reset mid-frame
        pulse_start();
        wait_pix(500);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_a", int'({a_rden, a_addr, a_fval, a_dval, a_data, a_busy, a_done}), 0);
        check("async_reset_b", int'({b_fval, b_dval, b_busy}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tra.delete();
        repeat (10) @(negedge clk);
        r = analyze(tra);
        check("post_reset_idle", r.fval_hi + r.nreads + r.ndone, 0);
        check("post_reset_busy", int'(a_busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/img_frame_streamer.md
# img_frame_streamer

Reads a 28x28 image back out of the 16-lane data memory and replays it as a camera-style pixel stream (FVAL/DVAL/DATA), 16 pixels per memory word, lane 0 first. It is the transmit-side counterpart of the image capture path. It drives test frames from stored images into the pixel-stream consumers and closes the capture → memory → stream loopback for self-test.

## Interface
- PIX_W, 16, pixel width
- LANES, 16, pixels per memory word (must be ≥2)
- NWORDS, 49, words per frame (NWORDS*LANES = 784 pixels)
- ADDR_W, 7, memory address width
- FRONT_PORCH, 2, cycles with FVAL=1, DVAL=0 before the first pixel (≥1)
- BACK_PORCH, 2, cycles with FVAL=1, DVAL=0 after the last pixel (≥0)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- iEnable  in  1  block enable; low aborts any frame
- iStart  in  1  frame request, level-sampled in IDLE
- iStall  in  1  consumer backpressure; pauses pixel output
- oMem_rden  out  1  memory read strobe
- oMem_addr  out  ADDR_W  memory word address
- iMem_data  in  LANES x PIX_W  read data, valid exactly 1 cycle after oMem_rden
- oFVAL  out  1  frame valid
- oDVAL  out  1  pixel valid
- oDATA  out  PIX_W  pixel
- oBusy  out  1  high in any state other than IDLE
- oDone  out  1  one-cycle pulse at frame end

## Operation
- All outputs are registered. The reset value of every output is 0.
- States: IDLE, FETCH, FRONT, STREAM, BACK.
- IDLE: when iEnable & iStart, go to FETCH. Drive oMem_rden=1 and oMem_addr=0 for one cycle. iStart seen in any other state is ignored.
- FETCH: wait one cycle. Load iMem_data into the shift buffer, set oFVAL=1, go to FRONT.
- FRONT: count FRONT_PORCH cycles with FVAL=1, then go to STREAM.
- STREAM: each non-stalled cycle, output buffer lane `lane` with DVAL=1, then advance `lane`.
  - Prefetch: on the cycle lane 0 of word k is output (k < NWORDS-1), issue oMem_rden with oMem_addr = k+1. Capture the returned data into the prefetch register.
  - After lane LANES-1 is output, the prefetch register moves into the shift buffer, so word boundaries have no gap.
  - Each address 0..NWORDS-1 is read exactly once per frame.
- iStall=1 in STREAM: DVAL=0 and oDATA=0 in the following cycle. lane, word and the buffer are frozen; FVAL stays 1. A prefetch already issued still completes.
- After pixel NWORDS*LANES-1, go to BACK. Count BACK_PORCH cycles, then drop FVAL, pulse oDone in that same cycle, and return to IDLE.
- oDATA = 0 whenever DVAL=0.
- iEnable low in any non-IDLE state: return to IDLE next cycle with FVAL=DVAL=rden=0. No oDone; partial frame discarded.
- Reset mid-frame: all outputs 0 immediately, state IDLE.
- Counters: pixel index 0..783, 10 bits. Word index wraps only at frame restart.

## Timing
- Start accepted at edge E0. rden/addr=0 is visible after E0. FVAL rises after E0+2. The first DVAL is after E0+2+FRONT_PORCH.
- With no stall, DVAL is high for exactly NWORDS*LANES consecutive cycles.
- FVAL stays high for FRONT_PORCH + 784 + stall cycles + BACK_PORCH.
- Back-to-back frames: iStart held high gives at least one IDLE cycle with FVAL=0 between frames.
- iStall takes effect with one cycle of latency: a stall sampled at edge E blocks the pixel after E+1.

## Test plan
- Memory model with word a, lane l = a*16+l. Start once with no stall → 784 DVAL cycles, DATA 0..783 in order, addresses 0..48 each read once, one oDone coincident with FVAL fall, FVAL high 788 cycles.
- Porch check with FRONT_PORCH=3, BACK_PORCH=0 → exactly 3 FVAL-only cycles before pixel 0 and none after pixel 783.
- Stall pulses of 1 and 5 cycles at pixel 15 (word boundary) and pixel 400 → sequence still 0..783 with no duplicates or drops, and no extra memory reads.
- iEnable dropped at pixel 200 → FVAL/DVAL 0 next cycle, no oDone. A new start then yields a full frame beginning at DATA=0 from address 0.
- iStart held high for 3 frames, plus iStart pulsed mid-frame → mid-frame start ignored, each frame a complete 784 pixels, FVAL low ≥1 cycle between frames.
- Reset asserted at pixel 500 → all outputs 0 asynchronously. After release, idle until start.
